// File: rtl/fib_stream_gen.sv
// rtl/fib_stream_gen.sv - Fibonacci-style term stream generator with valid/ready output
module fib_stream_gen #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   input  logic [CNT_W-1:0] num_terms,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_idx,
   output logic             out_ovf,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             tag_a;
   logic             tag_b;
   logic             mode;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] idx;
   logic             ovf_flag;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] next_term;
   logic             accept;
   logic             hs;

   // The carry out of the widened sum is both the saturation trigger and the new term's tag.
   assign sum       = {1'b0, a} + {1'b0, b};
   assign next_term = (mode && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      hs        = 1'b0;
      case (state)
         IDLE: begin
            if (!clear && start) begin
               accept    = 1'b1;
               state_nxt = (num_terms != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (clear) begin
               state_nxt = IDLE;
            end else if (out_ready) begin
               hs = 1'b1;
               if (remaining == CNT_W'(1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a         <= '0;
         b         <= '0;
         tag_a     <= 1'b0;
         tag_b     <= 1'b0;
         mode      <= 1'b0;
         remaining <= '0;
         idx       <= '0;
         ovf_flag  <= 1'b0;
      end else if (accept) begin
         a         <= seed_a;
         b         <= seed_b;
         tag_a     <= 1'b0;
         tag_b     <= 1'b0;
         mode      <= sat_mode;
         remaining <= num_terms;
         idx       <= '0;
         ovf_flag  <= 1'b0;
      end else if (hs) begin
         a         <= b;
         tag_a     <= tag_b;
         b         <= next_term;
         tag_b     <= sum[WIDTH];
         idx       <= idx + CNT_W'(1);
         remaining <= remaining - CNT_W'(1);
         ovf_flag  <= ovf_flag | tag_a;
      end
   end

   assign out_data = a;
   assign out_idx  = idx;
   assign out_ovf  = tag_a;
   assign overflow = ovf_flag;

endmodule

// File: tb/tb_fib_stream_gen.sv
// tb/tb_fib_stream_gen.sv - self-checking bench for fib_stream_gen (16-bit and 8-bit instances)
module tb_fib_stream_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        clear;
   logic [15:0] seed_a;
   logic [15:0] seed_b;
   logic [7:0]  num_terms;
   logic        sat_mode;
   logic        out_ready;

   logic [15:0] d16_data;
   logic        d16_valid, d16_ovf, d16_overflow, d16_busy, d16_done;
   logic [7:0]  d16_idx;
   logic [7:0]  d8_data;
   logic        d8_valid, d8_ovf, d8_overflow, d8_busy, d8_done;
   logic [7:0]  d8_idx;

   logic        use8 = 1'b0;
   logic [15:0] o_data;
   logic [7:0]  o_idx;
   logic        o_valid, o_ovf, o_overflow, o_busy, o_done;

   int npass = 0;
   int nfail = 0;
   int ncheck = 0;
   int exp_data [0:255];
   bit exp_ovf [0:255];
   bit exp_any;
   int pos;

   always #5 clk = ~clk;

   fib_stream_gen #(.WIDTH(16), .CNT_W(8)) dut16 (
      .clk(clk), .rst(rst), .start(start), .clear(clear),
      .seed_a(seed_a), .seed_b(seed_b), .num_terms(num_terms), .sat_mode(sat_mode),
      .out_data(d16_data), .out_valid(d16_valid), .out_ready(out_ready), .out_idx(d16_idx),
      .out_ovf(d16_ovf), .overflow(d16_overflow), .busy(d16_busy), .done(d16_done)
   );

   fib_stream_gen #(.WIDTH(8), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .clear(clear),
      .seed_a(seed_a[7:0]), .seed_b(seed_b[7:0]), .num_terms(num_terms), .sat_mode(sat_mode),
      .out_data(d8_data), .out_valid(d8_valid), .out_ready(out_ready), .out_idx(d8_idx),
      .out_ovf(d8_ovf), .overflow(d8_overflow), .busy(d8_busy), .done(d8_done)
   );

   assign o_data     = use8 ? {8'h00, d8_data} : d16_data;
   assign o_idx      = use8 ? d8_idx      : d16_idx;
   assign o_valid    = use8 ? d8_valid    : d16_valid;
   assign o_ovf      = use8 ? d8_ovf      : d16_ovf;
   assign o_overflow = use8 ? d8_overflow : d16_overflow;
   assign o_busy     = use8 ? d8_busy     : d16_busy;
   assign o_done     = use8 ? d8_done     : d16_done;

   task automatic check(input string tag, input int obs, input int expv);
      ncheck++;
      assert (obs === expv) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer Fibonacci with explicit overflow detection against 2^w.
   task automatic build_model(input int w, input int sa, input int sb, input int n, input bit md);
      int mask;
      int s;
      mask = (1 << w) - 1;
      exp_any = 1'b0;
      for (int i = 0; i < n && i < 256; i++) begin
         if (i == 0) begin
            exp_data[i] = sa & mask;
            exp_ovf[i]  = 1'b0;
         end else if (i == 1) begin
            exp_data[i] = sb & mask;
            exp_ovf[i]  = 1'b0;
         end else begin
            s = exp_data[i-1] + exp_data[i-2];
            exp_ovf[i]  = (s > mask);
            exp_data[i] = (s > mask) ? (md ? mask : s - (mask + 1)) : s;
         end
         exp_any = exp_any | exp_ovf[i];
      end
   endtask

   task automatic start_seq(input int w, input int sa, input int sb, input int n, input bit md);
      use8      = (w == 8);
      seed_a    = 16'(sa);
      seed_b    = 16'(sb);
      num_terms = 8'(n);
      sat_mode  = md;
      start     = 1'b1;
      build_model(w, sa, sb, n, md);
      tick();
      start     = 1'b0;
      pos       = 0;
   endtask

   task automatic check_term();
      check("valid", int'(o_valid), 1);
      check("data", int'(o_data), exp_data[pos]);
      check("idx", int'(o_idx), pos % 256);
      check("ovf", int'(o_ovf), int'(exp_ovf[pos]));
   endtask

   task automatic step_terms(input int k);
      for (int i = 0; i < k; i++) begin
         out_ready = 1'b1;
         check_term();
         tick();
         pos++;
      end
   endtask

   task automatic run_and_check(input int w, input int sa, input int sb, input int n,
                                input bit md, input int kind);
      int cyc;
      bit r;
      start_seq(w, sa, sb, n, md);
      cyc = 0;
      while (pos < n && cyc < 1000) begin
         case (kind)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready = r;
         check_term();
         tick();
         if (r) pos++;
         cyc++;
      end
      check("term_count", pos, n);
      if (kind == 0) check("consecutive_cycles", cyc, n);
      out_ready = 1'b0;
      check("done_pulse", int'(o_done), 1);
      check("valid_after_last", int'(o_valid), 0);
      check("busy_in_done", int'(o_busy), 1);
      check("overflow_sticky", int'(o_overflow), int'(exp_any));
      tick();
      check("done_cleared", int'(o_done), 0);
      check("busy_idle", int'(o_busy), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; clear = 1'b0; seed_a = '0; seed_b = '0;
      num_terms = '0; sat_mode = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_data", int'(d16_data), 0);
      check("rst_valid", int'(d16_valid), 0);
      check("rst_idx", int'(d16_idx), 0);
      check("rst_busy", int'(d16_busy), 0);
      check("rst_done", int'(d16_done), 0);
      check("rst_overflow", int'(d16_overflow), 0);
      rst = 1'b0;
      tick();

      // Basic 16-bit run, continuous and stalled.
      run_and_check(16, 0, 1, 10, 1'b0, 0);
      run_and_check(16, 0, 1, 10, 1'b0, 1);

      // 8-bit overflow: wrap then saturate.
      run_and_check(8, 0, 1, 15, 1'b0, 0);
      run_and_check(8, 0, 1, 15, 1'b1, 0);

      // Zero-length request.
      start_seq(16, 7, 9, 0, 1'b0);
      check("zero_done", int'(o_done), 1);
      check("zero_busy", int'(o_busy), 1);
      check("zero_valid", int'(o_valid), 0);
      tick();
      check("zero_done_end", int'(o_done), 0);
      check("zero_busy_end", int'(o_busy), 0);
      check("zero_valid_end", int'(o_valid), 0);

      // Asynchronous reset mid-run at term 4, after an overflowed term was accepted.
      start_seq(8, 100, 100, 10, 1'b0);
      step_terms(4);
      check("pre_rst_overflow", int'(o_overflow), 1);
      check("pre_rst_idx", int'(o_idx), 4);
      #3;
      rst = 1'b1;
      #1;
      check("arst_data", int'(o_data), 0);
      check("arst_valid", int'(o_valid), 0);
      check("arst_idx", int'(o_idx), 0);
      check("arst_ovf", int'(o_ovf), 0);
      check("arst_overflow", int'(o_overflow), 0);
      check("arst_busy", int'(o_busy), 0);
      check("arst_done", int'(o_done), 0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("post_rst_valid", int'(o_valid), 0);
      check("post_rst_busy", int'(o_busy), 0);
      run_and_check(16, 3, 4, 3, 1'b0, 0);

      // Start ignored while running, then clear aborts without a done pulse.
      start_seq(8, 100, 100, 10, 1'b0);
      step_terms(4);
      seed_a = 16'd5; seed_b = 16'd6; num_terms = 8'd2; start = 1'b1;
      step_terms(2);
      start = 1'b0;
      out_ready = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_valid", int'(o_valid), 0);
      check("clear_done", int'(o_done), 0);
      check("clear_busy", int'(o_busy), 0);
      check("clear_overflow_kept", int'(o_overflow), 1);
      tick();
      check("clear_no_done", int'(o_done), 0);
      check("clear_idle_valid", int'(o_valid), 0);
      out_ready = 1'b0;

      // Randomized runs with random back-pressure.
      for (int k = 0; k < 8; k++) begin
         int w;
         w = ($urandom_range(0, 1) == 1) ? 8 : 16;
         run_and_check(w, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)), 2);
      end

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule
